imem_sync_loader: RTL
=====================

// Module: imem_sync_loader
// PURPOSE
//  Parametrised, clocked instruction memory for the RV32 core. It has a registered fetch port
//  with one-cycle latency and alignment/range fault detection. It also has a byte-serial
//  program loader (valid/ready) that packs little-endian bytes into words, so a program can be
//  loaded at runtime from a host/UART bridge instead of by bench $readmemh.
//  Sits between the PC/fetch stage and the host link.
// PARAMETERS
//  DEPTH      256           number of 32-bit words; power of two, >= 4
//  BASE_ADDR  32'h0000_0000 byte address of word 0; 4-byte aligned
//  NOP_INSTR  32'h0000_0013 value driven on a faulted fetch and after reset (addi x0,x0,0)
// PORTS
//  clk           in   1   rising-edge clock
//  rst_n         in   1   asynchronous active-low reset
//  fetch_req     in   1   fetch request; sampled on clk
//  fetch_addr    in   32  byte address of the instruction
//  fetch_valid   out  1   fetch_instr/fetch_fault are valid (one cycle after an accepted req)
//  fetch_instr   out  32  fetched instruction, or NOP_INSTR on fault
//  fetch_fault   out  2   [0]=misaligned, [1]=out of range; valid with fetch_valid
//  ld_start      in   1   begin a program load at word 0 (honoured in IDLE only)
//  ld_byte_valid in   1   loader byte present
//  ld_byte       in   8   loader byte, little-endian within each word
//  ld_last       in   1   qualifies the final byte of the image (with ld_byte_valid)
//  ld_ready      out  1   loader accepts a byte this cycle
//  ld_busy       out  1   FSM in LOAD
//  ld_done       out  1   one-cycle pulse when a load finishes
//  ld_full       out  1   sticky: last load stopped at DEPTH words; cleared by next ld_start
//  ld_words      out  $clog2(DEPTH)+1  words written by the current/last load
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - fetch_valid=0, fetch_instr=NOP_INSTR, fetch_fault=0.
//   - ld_ready=0, ld_busy=0, ld_done=0, ld_full=0, ld_words=0.
//   - FSM=IDLE; byte lane and shift register cleared.
//   - Memory array is NOT reset; its contents survive reset.
//  FSM: IDLE, LOAD.
//   - IDLE -> LOAD on ld_start. On entry: ptr=0, lane=0, ld_words=0, ld_full=0.
//   - LOAD: ld_ready=1. Byte accepted when ld_byte_valid && ld_ready; it is stored in lane
//     `lane` (bits [8*lane+7:8*lane]) and lane increments.
//   - On the 4th byte, or on a byte with ld_last: the word (unfilled upper lanes = 0) is
//     written to mem[ptr] that edge; ptr++, ld_words++, lane=0.
//   - ld_last accepted -> IDLE, ld_done pulses the next cycle.
//   - A word written to ptr=DEPTH-1 without ld_last -> IDLE, ld_full=1, ld_done pulse.
//     Later bytes are not accepted (ld_ready=0).
//   - ld_start while in LOAD is ignored.
//  Fetch (IDLE only; 1-cycle latency):
//   - A fetch_req in IDLE at edge N gives fetch_valid=1 after edge N+1, holding the result
//     for the address sampled at N.
//   - fetch_valid=0 whenever no request was accepted the previous cycle.
//   - off = fetch_addr - BASE_ADDR; idx = off[31:2].
//   - misaligned = fetch_addr[1:0]!=0; oob = fetch_addr<BASE_ADDR || idx>=DEPTH.
//   - Any fault: fetch_instr=NOP_INSTR and the fault bits are set; both may be set together.
//   - fetch_req during LOAD is not accepted: fetch_valid=0 and fetch_instr holds its last
//     value. The core stalls on !fetch_valid.
//   - Same cycle fetch_req+ld_start in IDLE: the fetch is served; LOAD begins that edge.
//   - A fetch of a word written by the loader on the same edge is impossible (no fetch in LOAD).
//  Reset mid-load: FSM->IDLE; the partially packed word is discarded; words already written
//  are kept; ld_words=0.
// TESTING
//  1 Load bytes 13 00 00 00 93 00 50 00 (ld_last on 8th) -> mem[0]=0x00000013,
//    mem[1]=0x00500093; ld_words=2; ld_done pulses once.
//  2 Fetch 0x0, then 0x4 on consecutive cycles -> fetch_valid 1 cycle later:
//    0x00000013, then 0x00500093; fault=0.
//  3 Fetch 0x6 -> NOP_INSTR, fault=2'b01. Fetch 4*DEPTH -> NOP_INSTR, fault=2'b10.
//    Fetch 4*DEPTH+2 -> NOP_INSTR, fault=2'b11.
//  4 Load 3 bytes AA BB CC with ld_last on CC -> mem[0]=0x00CCBBAA; ld_words=1.
//  5 Stream 4*DEPTH+4 bytes with no ld_last -> ld_full=1, ld_words=DEPTH;
//    ld_ready=0 after the DEPTH-th word; mem[DEPTH-1] holds the last packed word.
//  6 Assert rst_n=0 after 2 bytes of a load; release; fetch 0x0 -> previous mem[0]
//    unchanged; FSM IDLE; ld_busy=0. Fetch during LOAD -> fetch_valid stays 0.

Source files
------------

// File: rtl/imem_sync_loader.sv
// Instruction memory with a registered one-cycle fetch port and a byte-serial program loader.
// Loader bytes are packed little-endian into words and written sequentially from word 0.
module imem_sync_loader #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_req,
  input  logic [31:0]              fetch_addr,
  output logic                     fetch_valid,
  output logic [31:0]              fetch_instr,
  output logic [1:0]               fetch_fault,
  input  logic                     ld_start,
  input  logic                     ld_byte_valid,
  input  logic [7:0]               ld_byte,
  input  logic                     ld_last,
  output logic                     ld_ready,
  output logic                     ld_busy,
  output logic                     ld_done,
  output logic                     ld_full,
  output logic [$clog2(DEPTH):0]   ld_words
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LAST_PTR = (AW+1)'(DEPTH - 1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t      state;
  logic [31:0] mem [DEPTH];
  logic [1:0]  lane;
  logic [31:0] shreg;

  logic        byte_acc;
  logic        word_wr;
  logic [31:0] word_next;
  logic [31:0] off;
  logic        misaligned;
  logic        oob;
  logic        fetch_acc;

  always_comb begin
    byte_acc   = ld_ready && ld_byte_valid;
    word_next  = shreg | ({24'b0, ld_byte} << {lane, 3'b000});
    word_wr    = byte_acc && ((lane == 2'd3) || ld_last);
    off        = fetch_addr - BASE_ADDR;
    // BASE_ADDR is word aligned, so the low offset bits equal the low address bits.
    misaligned = |off[1:0];
    oob        = (fetch_addr < BASE_ADDR) || ({2'b00, off[31:2]} >= 32'(DEPTH));
    fetch_acc  = fetch_req && (state == IDLE);
  end

  // NOTE: the array has no reset so it maps onto RAM and keeps the loaded program across rst_n.
  always_ff @(posedge clk) begin
    if (word_wr) mem[ld_words[AW-1:0]] <= word_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lane        <= '0;
      shreg       <= '0;
      ld_ready    <= 1'b0;
      ld_busy     <= 1'b0;
      ld_done     <= 1'b0;
      ld_full     <= 1'b0;
      ld_words    <= '0;
      fetch_valid <= 1'b0;
      fetch_instr <= NOP_INSTR;
      fetch_fault <= 2'b00;
    end else begin
      ld_done     <= 1'b0;
      fetch_valid <= fetch_acc;
      if (fetch_acc) begin
        fetch_fault <= {oob, misaligned};
        fetch_instr <= (oob || misaligned) ? NOP_INSTR : mem[off[AW+1:2]];
      end

      case (state)
        IDLE: begin
          if (ld_start) begin
            state    <= LOAD;
            ld_ready <= 1'b1;
            ld_busy  <= 1'b1;
            lane     <= '0;
            shreg    <= '0;
            ld_words <= '0;
            ld_full  <= 1'b0;
          end
        end
        LOAD: begin
          if (word_wr) begin
            shreg    <= '0;
            lane     <= '0;
            ld_words <= ld_words + 1'b1;
            // A final byte takes priority over the full condition on the last word.
            if (ld_last || (ld_words == LAST_PTR)) begin
              state    <= IDLE;
              ld_ready <= 1'b0;
              ld_busy  <= 1'b0;
              ld_done  <= 1'b1;
              ld_full  <= !ld_last;
            end
          end else if (byte_acc) begin
            shreg <= word_next;
            lane  <= lane + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
